// File: rtl/gb_mbc1_bank_ctrl.sv
// rtl/gb_mbc1_bank_ctrl.sv - MBC1-style bank controller: nWR sync, register decode, banked ROM/RAM addressing
module gb_mbc1_bank_ctrl #(
  parameter int ROM_ADDR_W     = 17,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_LOW_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           address,
  input  logic [7:0]            data_in,
  input  logic                  nWR,
  input  logic                  nRD,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [14:0]           ram_addr,
  output logic                  ram_rd_en,
  output logic                  ram_wr_stb,
  output logic [7:0]            ram_wdata,
  output logic                  ram_enabled
);

  localparam int CNT_W = $clog2(MIN_LOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_LOW_CYCLES);

  typedef enum logic [1:0] {IDLE, LOW, COMMIT} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [15:0]            cap_addr;
  logic [7:0]             cap_data;
  logic [4:0]             bank1;
  logic [1:0]             bank2;
  logic                   mode;
  logic [SYNC_STAGES-1:0] nwr_sync;
  logic [1:0]             nrd_sync;
  logic                   nwr_s;
  logic                   nrd_s;
  logic [1:0]             lo_bank;
  logic [20:0]            rom_full;

  assign nwr_s = nwr_sync[SYNC_STAGES-1];
  assign nrd_s = nrd_sync[1];

  // Strobes idle high, so the synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nwr_sync <= '1;
      nrd_sync <= 2'b11;
    end else begin
      nwr_sync <= {nwr_sync[SYNC_STAGES-2:0], nWR};
      nrd_sync <= {nrd_sync[0], nRD};
    end
  end

  always_comb begin
    lo_bank  = mode ? bank2 : 2'b00;
    rom_full = address[14] ? {bank2, bank1, address[13:0]}
                           : {lo_bank, 5'b00000, address[13:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_addr    <= '0;
      cap_data    <= '0;
      bank1       <= 5'd1;
      bank2       <= 2'd0;
      mode        <= 1'b0;
      rom_addr    <= '0;
      ram_addr    <= '0;
      ram_rd_en   <= 1'b0;
      ram_wr_stb  <= 1'b0;
      ram_wdata   <= '0;
      ram_enabled <= 1'b0;
    end else begin
      rom_addr   <= ROM_ADDR_W'(rom_full);
      ram_addr   <= {lo_bank, address[12:0]};
      ram_rd_en  <= ram_enabled && (address[15:13] == 3'b101) && !nrd_s;
      ram_wr_stb <= 1'b0;

      case (state)
        IDLE: begin
          if (!nwr_s) begin
            state    <= LOW;
            cnt      <= CNT_W'(1);
            cap_addr <= address;
            cap_data <= data_in;
          end
        end
        LOW: begin
          if (!nwr_s) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            cap_addr <= address;
            cap_data <= data_in;
          end else if (cnt >= CNT_MAX) begin
            // Decode here so the new register state is visible during COMMIT.
            state <= COMMIT;
            case (cap_addr[15:13])
              3'b000: ram_enabled <= (cap_data[3:0] == 4'hA);
              3'b001: bank1 <= (cap_data[4:0] == 5'd0) ? 5'd1 : cap_data[4:0];
              3'b010: bank2 <= cap_data[1:0];
              3'b011: mode  <= cap_data[0];
              3'b101: begin
                if (ram_enabled) begin
                  ram_wr_stb <= 1'b1;
                  ram_wdata  <= cap_data;
                  ram_addr   <= {lo_bank, cap_addr[12:0]};
                end
              end
              default: ;
            endcase
          end else begin
            state <= IDLE;
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_mbc1_bank_ctrl.sv
// tb/tb_gb_mbc1_bank_ctrl.sv - scoreboard bench for gb_mbc1_bank_ctrl with directed bus writes and probes
module tb_gb_mbc1_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        nWR;
  logic        nRD;
  logic [16:0] rom_addr;
  logic [14:0] ram_addr;
  logic        ram_rd_en;
  logic        ram_wr_stb;
  logic [7:0]  ram_wdata;
  logic        ram_enabled;
  logic        chk = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       nm;
    logic [16:0] rom;
    logic [14:0] ram;
    logic        en;
    logic        rd;
  } lvl_t;

  typedef struct {
    logic [14:0] ram;
    logic [7:0]  wd;
  } stb_t;

  lvl_t lvl_q[$];
  stb_t stb_q[$];

  gb_mbc1_bank_ctrl #(.ROM_ADDR_W(17), .SYNC_STAGES(2), .MIN_LOW_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .nWR(nWR), .nRD(nRD), .rom_addr(rom_addr), .ram_addr(ram_addr),
    .ram_rd_en(ram_rd_en), .ram_wr_stb(ram_wr_stb), .ram_wdata(ram_wdata),
    .ram_enabled(ram_enabled)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int low_cycles);
    address = a;
    data_in = d;
    nWR     = 1'b0;
    repeat (low_cycles) tick();
    nWR = 1'b1;
    repeat (8) tick();
  endtask

  task automatic probe(input string nm, input logic [15:0] a, input logic nrd,
                       input logic [16:0] er, input logic [14:0] ea,
                       input logic een, input logic erd);
    lvl_t e;
    address = a;
    nRD     = nrd;
    repeat (4) tick();
    e.nm = nm; e.rom = er; e.ram = ea; e.en = een; e.rd = erd;
    lvl_q.push_back(e);
    chk = 1'b1;
    tick();
    chk = 1'b0;
    nRD = 1'b1;
  endtask

  task automatic expect_stb(input logic [14:0] ea, input logic [7:0] ed);
    stb_t s;
    s.ram = ea; s.wd = ed;
    stb_q.push_back(s);
  endtask

  always @(negedge clk) begin
    if (ram_wr_stb) begin
      tests++;
      if (stb_q.size() == 0) begin
        fails++;
        $display("FAIL stb_unexpected: got ram_addr=%h ram_wdata=%h, required no pulse", ram_addr, ram_wdata);
      end else begin
        stb_t s;
        s = stb_q.pop_front();
        if (ram_addr !== s.ram || ram_wdata !== s.wd) begin
          fails++;
          $display("FAIL stb_data: got ram_addr=%h ram_wdata=%h, required ram_addr=%h ram_wdata=%h",
                   ram_addr, ram_wdata, s.ram, s.wd);
        end
      end
    end
    if (chk) begin
      tests++;
      if (lvl_q.size() == 0) begin
        fails++;
        $display("FAIL probe_queue: probe strobe with no expectation queued");
      end else begin
        lvl_t e;
        e = lvl_q.pop_front();
        if (rom_addr !== e.rom || ram_addr !== e.ram || ram_enabled !== e.en || ram_rd_en !== e.rd) begin
          fails++;
          $display("FAIL %s: got rom=%h ram=%h en=%b rd=%b, required rom=%h ram=%h en=%b rd=%b",
                   e.nm, rom_addr, ram_addr, ram_enabled, ram_rd_en, e.rom, e.ram, e.en, e.rd);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; address = 16'h4000; data_in = 8'h00; nWR = 1'b1; nRD = 1'b1;
    repeat (2) tick();
    probe("reset_hold", 16'h4000, 1'b1, 17'h00000, 15'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset state and default bank
    probe("reset_bank1", 16'h4000, 1'b1, 17'h04000, 15'h0000, 1'b0, 1'b0);

    // Bank 0 write maps to 1, then bank 3
    bus_write(16'h2100, 8'h00, 6);
    probe("bank1_zero", 16'h4123, 1'b1, 17'h04123, 15'h0123, 1'b0, 1'b0);
    bus_write(16'h2000, 8'h03, 6);
    probe("bank1_3", 16'h4123, 1'b1, 17'h0C123, 15'h0123, 1'b0, 1'b0);

    // Short nWR pulse is a glitch
    bus_write(16'h2000, 8'h1F, 2);
    probe("glitch", 16'h4123, 1'b1, 17'h0C123, 15'h0123, 1'b0, 1'b0);

    // Only the low five bits count; 0x20 translates to bank 1
    bus_write(16'h2000, 8'h20, 6);
    probe("bank1_0x20", 16'h4123, 1'b1, 17'h04123, 15'h0123, 1'b0, 1'b0);

    // RAM enable, RAM write, read enable
    bus_write(16'h0000, 8'h0A, 6);
    probe("ram_rd", 16'hA010, 1'b0, 17'h02010, 15'h0010, 1'b1, 1'b1);
    expect_stb(15'h0010, 8'h5A);
    bus_write(16'hA010, 8'h5A, 6);
    bus_write(16'h0000, 8'h00, 6);
    bus_write(16'hA010, 8'h5A, 6);
    probe("ram_disabled", 16'hA010, 1'b0, 17'h02010, 15'h0010, 1'b0, 1'b0);

    // bank2=1, mode=1
    bus_write(16'h4000, 8'h01, 6);
    bus_write(16'h6000, 8'h01, 6);
    probe("mode1_low", 16'h0100, 1'b1, 17'h00100, 15'h2100, 1'b0, 1'b0);
    probe("mode1_ram", 16'hA000, 1'b0, 17'h02000, 15'h2000, 1'b0, 1'b0);
    probe("mode1_high", 16'h4123, 1'b1, 17'h04123, 15'h2123, 1'b0, 1'b0);
    bus_write(16'h0000, 8'h0A, 6);
    expect_stb(15'h2010, 8'h33);
    bus_write(16'hA010, 8'h33, 6);

    // Reset in the middle of a write to the bank register
    address = 16'h2000; data_in = 8'h07; nWR = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    nWR = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    probe("rst_mid_write", 16'h4000, 1'b1, 17'h04000, 15'h0000, 1'b0, 1'b0);
    bus_write(16'h2000, 8'h07, 6);
    probe("after_rst_write", 16'h4000, 1'b1, 17'h1C000, 15'h0000, 1'b0, 1'b0);

    repeat (4) tick();
    tests++;
    if (stb_q.size() != 0) begin
      fails++;
      $display("FAIL stb_missing: got %0d pulses outstanding, required 0", stb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
